// File: rtl/uart_cmd_dispatcher_if.sv
// Bus bundle between the host UART pair, the command dispatcher and the motor channels.
// The slave modport is the dispatcher's view; the master modport is everything around it.
interface uart_cmd_dispatcher_if #(
  parameter int unsigned NUM_MOTORS = 10
);
  // Receive side (async_receiver)
  logic                     rxValid;
  logic [7:0]               rxData;
  // Motor command slots (motorCtrlSimple_v2)
  logic [32*NUM_MOTORS-1:0] cmdData;
  logic [NUM_MOTORS-1:0]    cmdValid;
  logic [NUM_MOTORS-1:0]    cmdAck;
  // Transmit side (async_transmitter)
  logic                     txStart;
  logic [7:0]               txData;
  logic                     txBusy;
  // Diagnostics
  logic [7:0]               errCount;

  modport master (
    output rxValid, rxData, cmdAck, txBusy,
    input  cmdData, cmdValid, txStart, txData, errCount
  );

  modport slave (
    input  rxValid, rxData, cmdAck, txBusy,
    output cmdData, cmdValid, txStart, txData, errCount
  );
endinterface

// File: rtl/uart_cmd_dispatcher.sv
// Host command dispatcher: parses 5-byte packets (index + 32-bit LSB-first payload), keeps one
// pending command per motor slot with a valid/ack handshake, and answers each packet with a
// one-byte status reply ('K' accepted, 'F' slot full, 'E' bad index) through the UART transmitter.
module uart_cmd_dispatcher #(
  parameter int unsigned NUM_MOTORS     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 24000
) (
  input  logic                 CLK_SE_AR,
  input  logic                 rst_n,
  uart_cmd_dispatcher_if.slave bus
);

  localparam int unsigned GapW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GapW-1:0] GapMax = GapW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPayload = 2'd1;
  localparam logic [1:0] StCommit  = 2'd2;

  localparam logic [7:0] RepOk   = 8'h4B;  // 'K'
  localparam logic [7:0] RepFull = 8'h46;  // 'F'
  localparam logic [7:0] RepErr  = 8'h45;  // 'E'

  // Parser state
  logic [1:0]      state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic [31:0]     shreg_q, shreg_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            timeout;

  // Command slots
  logic [32*NUM_MOTORS-1:0] cmd_data_q, cmd_data_d;
  logic [NUM_MOTORS-1:0]    cmd_valid_q, cmd_valid_d;
  logic                     commit;
  logic                     idx_in_range;
  logic                     accept;

  // Reply path and error counter
  logic       reply_pending_q, reply_pending_d;
  logic [7:0] reply_byte_q, reply_byte_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       launch;
  logic       drop;
  logic [7:0] err_q, err_d;

  assign commit       = (state_q == StCommit);
  assign idx_in_range = (32'(idx_q) < NUM_MOTORS);

  // Parser next state: index byte, four LSB-first payload bytes, then one commit cycle
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = gap_q;
    timeout    = 1'b0;
    case (state_q)
      StPayload: begin
        if (bus.rxValid) begin
          shreg_d    = {bus.rxData, shreg_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          gap_d      = '0;
          if (byte_cnt_q == 2'd3) begin
            state_d = StCommit;
          end
        end else if (gap_q == GapMax) begin
          // Host went quiet mid-packet: drop the partial packet silently
          state_d = StIdle;
          timeout = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: begin
        // Idle and commit both treat an arriving byte as the next index byte
        if (bus.rxValid) begin
          idx_d      = bus.rxData;
          byte_cnt_d = '0;
          gap_d      = '0;
          state_d    = StPayload;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Parser registers
  always_ff @(posedge CLK_SE_AR) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
    end
  end

  // Slot update: a commit wins over a same-cycle ack of the same slot, which frees it for reuse
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    accept      = 1'b0;
    for (int m = 0; m < NUM_MOTORS; m++) begin
      if (commit && (idx_q == 8'(m)) && (!cmd_valid_q[m] || bus.cmdAck[m])) begin
        cmd_valid_d[m]          = 1'b1;
        cmd_data_d[32*m +: 32]  = shreg_q;
        accept                  = 1'b1;
      end else if (bus.cmdAck[m]) begin
        cmd_valid_d[m] = 1'b0;
      end
    end
  end

  // Slot registers
  always_ff @(posedge CLK_SE_AR) begin
    if (!rst_n) begin
      cmd_valid_q <= '0;
      cmd_data_q  <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  // Launch only when idle and not in the cycle right after a start (busy may not be up yet)
  assign launch = reply_pending_q && !bus.txBusy && !tx_start_q;

  // Reply queue of depth one; a commit that finds an unsent reply overwrites it and counts a drop
  always_comb begin
    reply_pending_d = reply_pending_q;
    reply_byte_d    = reply_byte_q;
    tx_start_d      = 1'b0;
    tx_data_d       = tx_data_q;
    drop            = 1'b0;
    if (launch) begin
      tx_start_d      = 1'b1;
      tx_data_d       = reply_byte_q;
      reply_pending_d = 1'b0;
    end
    if (commit) begin
      reply_pending_d = 1'b1;
      drop            = reply_pending_q && !launch;
      if (!idx_in_range) begin
        reply_byte_d = RepErr;
      end else if (accept) begin
        reply_byte_d = RepOk;
      end else begin
        reply_byte_d = RepFull;
      end
    end
  end

  // Saturating error count; timeout and drop never coincide but are merged to count once anyway
  always_comb begin
    err_d = err_q;
    if ((timeout || drop) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Reply and error registers
  always_ff @(posedge CLK_SE_AR) begin
    if (!rst_n) begin
      reply_pending_q <= 1'b0;
      reply_byte_q    <= '0;
      tx_start_q      <= 1'b0;
      tx_data_q       <= '0;
      err_q           <= '0;
    end else begin
      reply_pending_q <= reply_pending_d;
      reply_byte_q    <= reply_byte_d;
      tx_start_q      <= tx_start_d;
      tx_data_q       <= tx_data_d;
      err_q           <= err_d;
    end
  end

  assign bus.cmdData  = cmd_data_q;
  assign bus.cmdValid = cmd_valid_q;
  assign bus.txStart  = tx_start_q;
  assign bus.txData   = tx_data_q;
  assign bus.errCount = err_q;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Bench for uart_cmd_dispatcher: directed scenarios plus randomized packets checked against a
// packet-level model of the slots, replies and error count.
module tb_uart_cmd_dispatcher;

  localparam int unsigned NM = 10;
  localparam int unsigned TO = 40;

  logic clk;
  logic rst_n;

  uart_cmd_dispatcher_if #(.NUM_MOTORS(NM)) bus ();

  uart_cmd_dispatcher #(
    .NUM_MOTORS    (NM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_SE_AR(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Packet-level reference model
  logic [NM-1:0]    exp_valid = '0;
  logic [32*NM-1:0] exp_data  = '0;
  int               exp_err   = 0;

  // Transmitter stand-in: records each started reply and stays busy a few clocks
  logic [7:0] tx_q[$];
  int         busy_cnt   = 0;
  logic       force_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.txStart === 1'b1) begin
      tx_q.push_back(bus.txData);
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.txBusy = force_busy || (busy_cnt > 0);
  end

  function automatic logic [7:0] model_commit(input logic [7:0] idx, input logic [31:0] pl,
                                               input logic [NM-1:0] ackv);
    logic ok;
    if (int'(idx) >= int'(NM)) begin
      exp_valid &= ~ackv;
      return 8'h45;
    end
    ok = !exp_valid[idx] || ackv[idx];
    exp_valid &= ~ackv;
    if (ok) begin
      exp_valid[idx]          = 1'b1;
      exp_data[32*idx +: 32]  = pl;
      return 8'h4B;
    end
    return 8'h46;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rxValid = 1'b1;
    bus.rxData  = b;
    @(negedge clk);
    bus.rxValid = 1'b0;
  endtask

  // Sends one packet; ackv is applied in the commit cycle, pre is cmdValid seen in that cycle
  task automatic send_packet(input logic [7:0] idx, input logic [31:0] pl, input int gap_lo,
                             input int gap_hi, input logic [NM-1:0] ackv,
                             output logic [NM-1:0] pre);
    logic [7:0] bytes [5];
    bytes[0] = idx;
    for (int i = 1; i < 5; i++) bytes[i] = pl[8*(i-1) +: 8];
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
      send_byte(bytes[i]);
    end
    bus.cmdAck = ackv;
    pre        = bus.cmdValid;
    @(negedge clk);
    bus.cmdAck = '0;
  endtask

  task automatic pulse_ack(input logic [NM-1:0] ackv);
    @(negedge clk);
    bus.cmdAck = ackv;
    @(negedge clk);
    bus.cmdAck = '0;
    exp_valid &= ~ackv;
  endtask

  task automatic get_reply(output logic got, output logic [7:0] b);
    got = 1'b0;
    b   = '0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (tx_q.size() > 0) begin
        b   = tx_q.pop_front();
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.cmdValid !== '0) begin
      n_bad++; $display("FAIL reset_cmdValid: got %h, expected 0", bus.cmdValid);
    end
    n_cmp++;
    if (bus.cmdData !== '0) begin
      n_bad++; $display("FAIL reset_cmdData: got %h, expected 0", bus.cmdData);
    end
    n_cmp++;
    if (bus.txStart !== 1'b0 || bus.txData !== 8'h00) begin
      n_bad++; $display("FAIL reset_tx: got start=%b data=%h, expected 0/00", bus.txStart, bus.txData);
    end
    n_cmp++;
    if (bus.errCount !== 8'h00) begin
      n_bad++; $display("FAIL reset_errCount: got %h, expected 00", bus.errCount);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_accept_and_full();
    logic [NM-1:0] pre, old_v;
    logic [7:0]    rep, b;
    logic          got;
    old_v = exp_valid;
    rep   = model_commit(8'd3, 32'h12345678, '0);
    send_packet(8'd3, 32'h12345678, 0, 0, '0, pre);
    n_cmp++;
    if (pre !== old_v) begin
      n_bad++; $display("FAIL t1_no_early_write: got %h, expected %h", pre, old_v);
    end
    n_cmp++;
    if (bus.cmdValid !== exp_valid) begin
      n_bad++; $display("FAIL t1_valid: got %h, expected %h", bus.cmdValid, exp_valid);
    end
    n_cmp++;
    if (bus.cmdData[3*32 +: 32] !== 32'h12345678) begin
      n_bad++; $display("FAIL t1_data: got %h, expected 12345678", bus.cmdData[3*32 +: 32]);
    end
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== rep) begin
      n_bad++; $display("FAIL t1_reply: got %h (seen=%b), expected %h", b, got, rep);
    end
    // Same slot again without ack: refused, contents kept
    rep = model_commit(8'd3, 32'hDEADBEEF, '0);
    send_packet(8'd3, 32'hDEADBEEF, 0, 2, '0, pre);
    n_cmp++;
    if (bus.cmdData[3*32 +: 32] !== 32'h12345678 || bus.cmdValid !== exp_valid) begin
      n_bad++; $display("FAIL t2_full_kept: got %h/%h, expected 12345678/%h",
                        bus.cmdData[3*32 +: 32], bus.cmdValid, exp_valid);
    end
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== rep) begin
      n_bad++; $display("FAIL t2_reply: got %h (seen=%b), expected %h", b, got, rep);
    end
    pulse_ack(NM'(1) << 3);
    n_cmp++;
    if (bus.cmdValid !== exp_valid || bus.cmdData[3*32 +: 32] !== 32'h12345678) begin
      n_bad++; $display("FAIL t2_release: got %h/%h, expected %h/12345678",
                        bus.cmdValid, bus.cmdData[3*32 +: 32], exp_valid);
    end
  endtask

  task automatic test_bad_index();
    logic [NM-1:0] pre;
    logic [7:0]    rep, b;
    logic          got;
    rep = model_commit(8'h0C, 32'h0BADF00D, '0);
    send_packet(8'h0C, 32'h0BADF00D, 0, 1, '0, pre);
    n_cmp++;
    if (bus.cmdValid !== exp_valid || bus.cmdData !== exp_data) begin
      n_bad++; $display("FAIL t3_no_change: got %h, expected %h", bus.cmdValid, exp_valid);
    end
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== rep) begin
      n_bad++; $display("FAIL t3_reply: got %h (seen=%b), expected %h", b, got, rep);
    end
    rep = model_commit(8'd0, 32'h00C0FFEE, '0);
    send_packet(8'd0, 32'h00C0FFEE, 0, 1, '0, pre);
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== rep || bus.cmdData[31:0] !== 32'h00C0FFEE || bus.cmdValid !== exp_valid) begin
      n_bad++; $display("FAIL t3_slot0: got %h/%h/%h, expected %h/00c0ffee/%h",
                        b, bus.cmdData[31:0], bus.cmdValid, rep, exp_valid);
    end
  endtask

  task automatic test_timeout();
    logic [NM-1:0] pre;
    logic [7:0]    rep, b;
    logic          got;
    send_byte(8'h01);
    send_byte(8'hAA);
    repeat (TO - 1) @(negedge clk);
    n_cmp++;
    if (int'(bus.errCount) !== exp_err) begin
      n_bad++; $display("FAIL t4_early_timeout: got %0d, expected %0d", bus.errCount, exp_err);
    end
    repeat (2) @(negedge clk);
    exp_err++;
    n_cmp++;
    if (int'(bus.errCount) !== exp_err) begin
      n_bad++; $display("FAIL t4_timeout_err: got %0d, expected %0d", bus.errCount, exp_err);
    end
    n_cmp++;
    if (tx_q.size() != 0 || bus.cmdValid !== exp_valid) begin
      n_bad++; $display("FAIL t4_silent: got %0d replies valid=%h, expected 0 replies valid=%h",
                        tx_q.size(), bus.cmdValid, exp_valid);
    end
    rep = model_commit(8'd2, 32'h02020202, '0);
    send_packet(8'd2, 32'h02020202, 0, 2, '0, pre);
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== rep || bus.cmdValid !== exp_valid || bus.cmdData !== exp_data) begin
      n_bad++; $display("FAIL t4_next_packet: got %h/%h, expected %h/%h", b, bus.cmdValid, rep,
                        exp_valid);
    end
  endtask

  task automatic test_ack_in_commit();
    logic [NM-1:0] pre;
    logic [7:0]    rep, b;
    logic          got;
    rep = model_commit(8'd5, 32'hA5A5A5A5, '0);
    send_packet(8'd5, 32'hA5A5A5A5, 0, 1, '0, pre);
    get_reply(got, b);
    rep = model_commit(8'd5, 32'h00000005, NM'(1) << 5);
    send_packet(8'd5, 32'h00000005, 0, 1, NM'(1) << 5, pre);
    n_cmp++;
    if (bus.cmdValid[5] !== 1'b1 || bus.cmdData[5*32 +: 32] !== 32'h00000005) begin
      n_bad++; $display("FAIL t5_refill: got %b/%h, expected 1/00000005", bus.cmdValid[5],
                        bus.cmdData[5*32 +: 32]);
    end
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== rep) begin
      n_bad++; $display("FAIL t5_reply: got %h (seen=%b), expected %h", b, got, rep);
    end
  endtask

  task automatic test_max_gap();
    logic [NM-1:0] pre;
    logic [7:0]    rep, b;
    logic          got;
    // Longest gap that still lands inside the timeout window
    rep = model_commit(8'd6, 32'h6060_0606, '0);
    send_packet(8'd6, 32'h6060_0606, TO - 2, TO - 2, '0, pre);
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== rep || int'(bus.errCount) !== exp_err || bus.cmdData !== exp_data) begin
      n_bad++; $display("FAIL max_gap: got reply %h err %0d, expected %h err %0d", b,
                        bus.errCount, rep, exp_err);
    end
  endtask

  task automatic test_busy_drop();
    logic [NM-1:0] pre;
    logic [7:0]    r2, b;
    logic          got;
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    void'(model_commit(8'd8, 32'h88888888, '0));
    send_packet(8'd8, 32'h88888888, 0, 1, '0, pre);
    r2 = model_commit(8'd8, 32'h99999999, '0);
    send_packet(8'd8, 32'h99999999, 0, 1, '0, pre);
    exp_err++;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (tx_q.size() != 0) begin
      n_bad++; $display("FAIL t6_start_while_busy: got %0d starts, expected 0", tx_q.size());
    end
    n_cmp++;
    if (int'(bus.errCount) !== exp_err) begin
      n_bad++; $display("FAIL t6_drop_err: got %0d, expected %0d", bus.errCount, exp_err);
    end
    force_busy = 1'b0;
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== r2) begin
      n_bad++; $display("FAIL t6_reply: got %h (seen=%b), expected %h", b, got, r2);
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (tx_q.size() != 0) begin
      n_bad++; $display("FAIL t6_single_start: got %0d extra starts, expected 0", tx_q.size());
    end
  endtask

  task automatic test_random();
    logic [NM-1:0] pre, ackv;
    logic [7:0]    idx, rep, b;
    logic [31:0]   pl;
    logic          got;
    for (int n = 0; n < 60; n++) begin
      idx  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(NM, 255)) : 8'($urandom_range(0, NM - 1));
      pl   = $urandom;
      ackv = NM'($urandom & $urandom & $urandom);
      rep  = model_commit(idx, pl, ackv);
      send_packet(idx, pl, 0, 3, ackv, pre);
      n_cmp++;
      if (bus.cmdValid !== exp_valid) begin
        n_bad++; $display("FAIL rnd_valid[%0d]: got %h, expected %h", n, bus.cmdValid, exp_valid);
      end
      n_cmp++;
      if (bus.cmdData !== exp_data) begin
        n_bad++; $display("FAIL rnd_data[%0d]: got %h, expected %h", n, bus.cmdData, exp_data);
      end
      get_reply(got, b);
      n_cmp++;
      if (!got || b !== rep) begin
        n_bad++; $display("FAIL rnd_reply[%0d]: got %h (seen=%b), expected %h", n, b, got, rep);
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_ack(NM'($urandom));
        n_cmp++;
        if (bus.cmdValid !== exp_valid) begin
          n_bad++; $display("FAIL rnd_ack[%0d]: got %h, expected %h", n, bus.cmdValid, exp_valid);
        end
      end
    end
  endtask

  task automatic test_reset_midpacket();
    logic [NM-1:0] pre;
    logic [7:0]    rep, b;
    logic          got;
    repeat (10) @(negedge clk);
    send_byte(8'h07);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.cmdValid !== '0 || bus.cmdData !== '0 || bus.txStart !== 1'b0 ||
        bus.txData !== 8'h00 || bus.errCount !== 8'h00) begin
      n_bad++; $display("FAIL midreset_outputs: got valid=%h tx=%b/%h err=%h, expected all 0",
                        bus.cmdValid, bus.txStart, bus.txData, bus.errCount);
    end
    rst_n = 1'b1;
    exp_valid = '0;
    exp_data  = '0;
    exp_err   = 0;
    tx_q.delete();
    rep = model_commit(8'd4, 32'hCAFEF00D, '0);
    send_packet(8'd4, 32'hCAFEF00D, 0, 1, '0, pre);
    get_reply(got, b);
    n_cmp++;
    if (!got || b !== rep || bus.cmdValid !== exp_valid || bus.cmdData !== exp_data) begin
      n_bad++; $display("FAIL midreset_next: got %h/%h, expected %h/%h", b, bus.cmdValid, rep,
                        exp_valid);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxData  = '0;
    bus.cmdAck  = '0;
    test_reset();
    test_accept_and_full();
    test_bad_index();
    test_timeout();
    test_ack_in_commit();
    test_max_gap();
    test_busy_drop();
    test_random();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
